updn_counter_mod: RTL

Parametrised synchronous up/down modulo counter with enable, synchronous clear, parallel load and terminal-count/wrap flags. Generalises the fixed 3-bit gate-level up-counter to any width and modulus, with direction control and a build-time saturating mode. Used as the general-purpose sequencing counter for timers, address generators and divide-by-N strobes in the datapath.

---
 rtl/updn_counter_mod.sv | 106 ++++++++++
 1 files changed

// File: rtl/updn_counter_mod.sv
// Parametrised up/down modulo counter with clear, load and wrap flags.
// Build with UDCNT_SATURATE_EN defined to saturate instead of wrapping.
module updn_counter_mod #(
  parameter int              WIDTH  = 3,
  parameter longint unsigned MODULO = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
);

  localparam int W1 = WIDTH + 1;

  // MODULO may equal 2**WIDTH, so the top
  // value is compared one bit wider.
  localparam logic [W1-1:0] MAXV =
    W1'(MODULO - 1);
  localparam logic [WIDTH-1:0] MAXW =
    WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ONE =
    WIDTH'(1);

`ifdef UDCNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             at_max;
  logic             at_min;
  logic             term;
  logic             do_clr;
  logic             do_load;
  logic             do_step;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] dn_val;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] nxt;
  logic             nxt_wrap;

  // Terminal detection for the current direction.
  always_comb begin
    at_max = {1'b0, count} == MAXV;
    at_min = count == '0;
    term   = up_dn ? at_max : at_min;
  end

  assign tc = en & ~clr & ~load & term;

  // Candidate values: step either way, clamped load.
  always_comb begin
    if (at_max)
      up_val = SAT ? MAXW : '0;
    else
      up_val = count + ONE;
    if (at_min)
      dn_val = SAT ? '0 : MAXW;
    else
      dn_val = count - ONE;
    if ({1'b0, load_val} > MAXV)
      ld_val = MAXW;
    else
      ld_val = load_val;
  end

  // One-hot priority: clr, then load, then en.
  always_comb begin
    do_clr  = clr;
    do_load = ~clr & load;
    do_step = ~clr & ~load & en;
  end

  // Next count and wrap pulse from the winning action.
  always_comb begin
    nxt      = count;
    nxt_wrap = 1'b0;
    unique case (1'b1)
      do_clr:  nxt = '0;
      do_load: nxt = ld_val;
      do_step: begin
        nxt      = up_dn ? up_val : dn_val;
        nxt_wrap = term;
      end
      default: ;
    endcase
  end

  // Count and wrap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      wrapped <= 1'b0;
    end else begin
      count   <= nxt;
      wrapped <= nxt_wrap;
    end
  end

endmodule
